or1200_except_req_arb: RTL and testbench

//  Collects exception trigger sources and holds edge-type events pending.

---
 rtl/or1200_except_req_arb.sv | 107 ++++++++++
 tb/tb_or1200_except_req_arb.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/or1200_except_req_arb.sv
// Exception request arbiter: latches trigger sources, picks the highest-index
// enabled one and offers it to the flush FSM over a valid/ack handshake.
module or1200_except_req_arb #(
  parameter int              NSRC    = 14,
  parameter int              IDW     = 4,
  parameter logic [NSRC-1:0] STICKY  = 14'h3FFF,
  parameter int              HOLDOFF = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] trig_i,
  input  logic [NSRC-1:0] mask_i,
  input  logic            flush_busy_i,
  output logic            req_o,
  output logic [IDW-1:0]  req_id_o,
  input  logic            ack_i,
  output logic [NSRC-1:0] pending_o,
  output logic [7:0]      ovr_cnt_o
);

  // state | meaning
  // IDLE  | waiting for an eligible source while the flush FSM is idle
  // OFFER | req_o high, req_id_o frozen until ack_i
  // HOLD  | post-ack gap, down-counter runs to zero before re-arming
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LD = 4'(HOLDOFF);

  state_t          state;
  logic [3:0]      hold_cnt;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] trig_q;
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] pend_nxt;
  logic [NSRC-1:0] ovr_hit;
  logic [NSRC-1:0] elig;
  logic [IDW-1:0]  winner;

  always_comb begin
    clr      = '0;
    pend_nxt = '0;
    ovr_hit  = '0;
    for (int i = 0; i < NSRC; i++) begin
      clr[i] = (state == OFFER) && ack_i && (req_id_o == IDW'(i)) && STICKY[i];
      // A new trigger in the ack cycle wins over the clear.
      pend_nxt[i] = STICKY[i] ? (trig_i[i] | (pend[i] & ~clr[i])) : trig_i[i];
      ovr_hit[i]  = STICKY[i] & trig_i[i] & ~trig_q[i] & pend[i] & ~clr[i];
    end
  end

  assign elig = pend & mask_i;

  always_comb begin
    winner = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (elig[i]) winner = IDW'(i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      pend      <= '0;
      trig_q    <= '0;
      req_o     <= 1'b0;
      req_id_o  <= '0;
      ovr_cnt_o <= '0;
    end else begin
      pend   <= pend_nxt;
      trig_q <= trig_i;
      if ((|ovr_hit) && (ovr_cnt_o != 8'hFF)) ovr_cnt_o <= ovr_cnt_o + 8'd1;

      case (state)
        IDLE: begin
          if ((|elig) && !flush_busy_i) begin
            state    <= OFFER;
            req_o    <= 1'b1;
            req_id_o <= winner;
          end
        end
        OFFER: begin
          if (ack_i) begin
            state    <= HOLD;
            req_o    <= 1'b0;
            hold_cnt <= HOLD_LD;
          end
        end
        HOLD: begin
          if (hold_cnt != 4'd0) hold_cnt <= hold_cnt - 4'd1;
          else if (!flush_busy_i) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          req_o <= 1'b0;
        end
      endcase
    end
  end

  assign pending_o = pend;

endmodule

// File: tb/tb_or1200_except_req_arb.sv
// Scoreboard bench for or1200_except_req_arb: stimulus queues expected offers
// (id and arrival cycle), a monitor pops and compares each offer seen.
module tb_or1200_except_req_arb;

  localparam int              NSRC    = 14;
  localparam int              IDW     = 4;
  localparam logic [NSRC-1:0] STICKY  = 14'h3FFB;
  localparam int              HOLDOFF = 2;

  typedef struct {
    int id;
    int cyc;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [NSRC-1:0] trig;
  logic [NSRC-1:0] mask;
  logic            busy;
  logic            ack;
  logic            req;
  logic [IDW-1:0]  req_id;
  logic [NSRC-1:0] pending;
  logic [7:0]      ovr_cnt;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic auto_ack = 1'b0;
  exp_t sb[$];

  or1200_except_req_arb #(
    .NSRC(NSRC), .IDW(IDW), .STICKY(STICKY), .HOLDOFF(HOLDOFF)
  ) dut (
    .clk(clk), .reset(reset), .trig_i(trig), .mask_i(mask),
    .flush_busy_i(busy), .req_o(req), .req_id_o(req_id), .ack_i(ack),
    .pending_o(pending), .ovr_cnt_o(ovr_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_offer(input int id, input int at);
    exp_t e;
    e.id  = id;
    e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      tick(1);
      t++;
    end
    check("drain_queue", sb.size(), 0);
    tick(HOLDOFF + 4);
  endtask

  // Ack driver: answers a visible offer in the same cycle when enabled.
  initial begin
    ack = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      ack = auto_ack && req;
    end
  end

  // Monitor: compares every new offer against the head of the scoreboard.
  initial begin
    logic           seen;
    logic [IDW-1:0] held;
    exp_t           e;
    seen = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (req && !seen) begin
        seen = 1'b1;
        held = req_id;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_offer: actual id %0d at cycle %0d, required no offer", req_id, cyc);
        end else begin
          e = sb.pop_front();
          check("offer_id", 32'(req_id), e.id);
          check("offer_cycle", cyc, e.cyc);
        end
      end else if (req) begin
        check("offer_id_stable", 32'(req_id), 32'(held));
      end else begin
        seen = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    reset = 1'b0;
    trig  = '0;
    mask  = '1;
    busy  = 1'b0;
    tick(3);
    check("rst_req", req, 0);
    check("rst_id", req_id, 0);
    check("rst_pending", pending, 0);
    check("rst_ovr", ovr_cnt, 0);
    reset = 1'b1;
    tick(2);

    // single source, bit 5
    auto_ack = 1'b1;
    c0 = cyc;
    trig = 14'h0020;
    expect_offer(5, c0 + 2);
    tick(1);
    trig = '0;
    check("t1_pending_set", pending, 14'h0020);
    drain();
    check("t1_pending_clr", pending, 0);

    // priority: 13, 8, 1 spaced HOLDOFF+3
    c0 = cyc;
    trig = 14'h2102;
    expect_offer(13, c0 + 2);
    expect_offer(8, c0 + 2 + (HOLDOFF + 3));
    expect_offer(1, c0 + 2 + 2 * (HOLDOFF + 3));
    tick(1);
    trig = '0;
    drain();
    check("t2_pending_clr", pending, 0);

    // busy gate
    busy = 1'b1;
    trig = 14'h0080;
    tick(1);
    trig = '0;
    for (int k = 0; k < 9; k++) begin
      tick(1);
      check("t3_busy_no_req", req, 0);
    end
    busy = 1'b0;
    expect_offer(7, cyc + 1);
    drain();

    // overrun: two re-pulses of bit 3 while the offer waits
    auto_ack = 1'b0;
    c0 = cyc;
    trig = 14'h0008;
    expect_offer(3, c0 + 2);
    tick(1);
    trig = '0;
    tick(1);
    trig = 14'h0008;
    tick(1);
    trig = '0;
    tick(1);
    trig = 14'h0008;
    tick(1);
    trig = '0;
    tick(1);
    check("t4_ovr_two", ovr_cnt, 2);

    // re-pulse coinciding with the ack keeps bit 3 pending
    c0 = cyc;
    trig = 14'h0008;
    auto_ack = 1'b1;
    expect_offer(3, c0 + HOLDOFF + 3);
    tick(1);
    trig = '0;
    check("t4_collide_pending", pending, 14'h0008);
    check("t4_collide_ovr", ovr_cnt, 2);
    drain();
    check("t4_pending_clr", pending, 0);

    // level bit 2 rises and falls while blocked: nothing left to offer
    busy = 1'b1;
    trig = 14'h0004;
    tick(1);
    trig = '0;
    check("t5_level_set", pending, 14'h0004);
    tick(1);
    check("t5_level_drop", pending, 0);
    busy = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      check("t5_level_no_req", req, 0);
    end

    // masked sticky bit 4 waits, then competes when re-enabled
    mask = 14'h3FEF;
    trig = 14'h0010;
    tick(1);
    trig = '0;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check("t5_mask_no_req", req, 0);
    end
    check("t5_mask_pending", pending, 14'h0010);
    mask = '1;
    expect_offer(4, cyc + 1);
    drain();
    check("t5_mask_pending_clr", pending, 0);

    // reset while offering id 9
    auto_ack = 1'b0;
    c0 = cyc;
    trig = 14'h0200;
    expect_offer(9, c0 + 2);
    tick(1);
    trig = '0;
    tick(2);
    check("t6_offer_up", req, 1);
    reset = 1'b0;
    #1;
    check("t6_rst_req", req, 0);
    check("t6_rst_id", req_id, 0);
    check("t6_rst_pending", pending, 0);
    check("t6_rst_ovr", ovr_cnt, 0);
    tick(1);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      check("t6_no_req_after", req, 0);
    end

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
